// File: rtl/pixel_splicer_nppc.sv
// pixel_splicer_nppc
//   AXI4-Stream video gearbox. Accepts PPC pixels per input beat and emits
//   them one pixel per output beat, pixel 0 (lowest bits) first. SOF (tuser)
//   and EOL (tlast) on the output are regenerated from internal x/y counters
//   against FRAME_WIDTH x FRAME_HEIGHT. Input beats before the first SOF are
//   dropped, and framing problems on the input are flagged.
//
// Ports
//   aclk, aresetn   clock (rising edge), async active-low reset
//   s_axis_*        input stream, PPC*PIXEL_WIDTH data, tuser=SOF, tlast=EOL
//   m_axis_*        output stream, one pixel per beat, tuser=(0,0), tlast=x end
//   sof_err         pulse: SOF seen on a beat inside a frame
//   eol_err         pulse: input tlast disagrees with the expected line end
//   frame_done      high in the cycle the last pixel of a frame transfers
module pixel_splicer_nppc #(
  parameter int PIXEL_WIDTH  = 24,
  parameter int PPC          = 2,
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 10
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [PPC*PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic [PIXEL_WIDTH-1:0]     m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       sof_err,
  output logic                       eol_err,
  output logic                       frame_done
);

  localparam int PW_W = (PPC > 1)          ? $clog2(PPC)          : 1;
  localparam int XW   = (FRAME_WIDTH > 1)  ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [PW_W-1:0] P_LAST = PW_W'(PPC - 1);
  localparam logic [XW-1:0]   X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST = YW'(FRAME_HEIGHT - 1);

  localparam logic [0:0] ST_WAIT_SOF = 1'b0;
  localparam logic [0:0] ST_ACTIVE   = 1'b1;

  logic [0:0]                          state_q, state_d;
  logic [PPC-1:0][PIXEL_WIDTH-1:0]     buf_q, buf_d;
  logic                                buf_vld_q, buf_vld_d;
  logic [PW_W-1:0]                     p_q, p_d;
  logic [XW-1:0]                       x_q, x_d;
  logic [YW-1:0]                       y_q, y_d;
  logic                                sof_err_q, sof_err_d;
  logic                                eol_err_q, eol_err_d;

  logic m_xfer, s_acc, frame_end, eff_wait;

  // Refill in the same cycle the last buffered pixel leaves: no bubbles.
  assign s_axis_tready = aresetn && (!buf_vld_q || (p_q == P_LAST && m_axis_tready));
  assign s_acc         = s_axis_tvalid && s_axis_tready;
  assign m_xfer        = buf_vld_q && m_axis_tready;
  assign frame_end     = m_xfer && (state_q == ST_ACTIVE) && (x_q == X_LAST) && (y_q == Y_LAST);
  // A beat accepted on the frame's final transfer is judged as if idle, so
  // an SOF there starts the next frame instead of counting as mid-frame.
  assign eff_wait      = (state_q == ST_WAIT_SOF) || frame_end;

  assign m_axis_tvalid = buf_vld_q;
  assign m_axis_tdata  = buf_vld_q ? buf_q[p_q] : '0;
  assign m_axis_tuser  = buf_vld_q && (x_q == '0) && (y_q == '0);
  assign m_axis_tlast  = buf_vld_q && (x_q == X_LAST);
  assign frame_done    = frame_end;
  assign sof_err       = sof_err_q;
  assign eol_err       = eol_err_q;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    p_d       = p_q;
    x_d       = x_q;
    y_d       = y_q;
    sof_err_d = 1'b0;
    eol_err_d = 1'b0;

    if (m_xfer) begin
      if (p_q == P_LAST) begin
        buf_vld_d = 1'b0;
        p_d       = '0;
      end else begin
        p_d = p_q + 1'b1;
      end
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // Leftover pixels after the frame's last one are dropped.
    if (frame_end) begin
      state_d   = ST_WAIT_SOF;
      buf_vld_d = 1'b0;
      p_d       = '0;
    end

    // Non-SOF beats while waiting are accepted and thrown away.
    if (s_acc && (s_axis_tuser || !eff_wait)) begin
      buf_d     = s_axis_tdata;
      buf_vld_d = 1'b1;
      p_d       = '0;
      state_d   = ST_ACTIVE;
      if (s_axis_tuser) begin
        x_d       = '0;
        y_d       = '0;
        sof_err_d = !eff_wait;
      end
      // x_d now holds the x of this beat's pixel 0; counters are not
      // corrected on a mismatch, only flagged.
      eol_err_d = s_axis_tlast != ((int'(x_d) + PPC) == FRAME_WIDTH);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_WAIT_SOF;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      p_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sof_err_q <= 1'b0;
      eol_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      p_q       <= p_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sof_err_q <= sof_err_d;
      eol_err_q <= eol_err_d;
    end
  end

endmodule

// File: tb/tb_pixel_splicer_nppc.sv
// Bench for pixel_splicer_nppc at default geometry (2 ppc, 10x10).
// Expected pixels are pushed by a beat-level reference model when each input
// beat is accepted, and popped/compared as output pixels transfer. Each test
// task also checks its own scenario-specific counts and pixels.
module tb_pixel_splicer_nppc;
  localparam int PW  = 24;
  localparam int PPC = 2;
  localparam int FW  = 10;
  localparam int FH  = 10;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [PPC*PW-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tuser = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic [PW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tuser;
  logic              m_axis_tlast;
  logic              sof_err, eol_err, frame_done;

  always #5 aclk = ~aclk;

  pixel_splicer_nppc #(.PIXEL_WIDTH(PW), .PPC(PPC), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .sof_err(sof_err), .eol_err(eol_err), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [PW-1:0] d;
    logic          u;
    logic          l;
    logic          fd;
  } pix_t;

  pix_t              exp_q[$];
  pix_t              got_q[$];
  logic [PPC*PW-1:0] bd_q[$];
  logic              bu_q[$];
  logic              bl_q[$];

  int n_checks = 0, n_pass = 0;
  int m_wait = 1, m_x = 0, m_y = 0;
  int got_sof, got_eol, got_fd, stall_viol, rdy_viol, timeouts;
  bit stop;

  // Reference model: consumes one accepted beat, pushes expected pixels.
  task automatic model_beat(input logic [PPC*PW-1:0] d, input logic u);
    pix_t p;
    if (u) begin
      m_wait = 0; m_x = 0; m_y = 0;
    end
    if (m_wait == 0) begin
      for (int k = 0; k < PPC; k++) begin
        if (m_wait != 0) break;
        p.d  = d[k*PW +: PW];
        p.u  = (m_x == 0) && (m_y == 0);
        p.l  = (m_x == FW-1);
        p.fd = (m_x == FW-1) && (m_y == FH-1);
        exp_q.push_back(p);
        if (m_x == FW-1) begin
          m_x = 0;
          if (m_y == FH-1) begin m_y = 0; m_wait = 1; end
          else m_y++;
        end else m_x++;
      end
    end
  endtask

  task automatic push_frame(input int base, input int sof2, input int drop_l, input int extra_l);
    for (int i = 0; i < FW*FH/PPC; i++) begin
      bd_q.push_back((PPC*PW)'(base + i));
      bu_q.push_back(i == 0 || i == sof2);
      bl_q.push_back(((i % (FW/PPC)) == FW/PPC-1 && i != drop_l) || i == extra_l);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; m_axis_tready = 1'b0;
    m_wait = 1; m_x = 0; m_y = 0;
    exp_q.delete(); bd_q.delete(); bu_q.delete(); bl_q.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  // Drives the queued beats, runs the output ready pattern and scoreboards
  // every output transfer.
  task automatic run_stream(input bit toggle);
    got_q.delete();
    got_sof = 0; got_eol = 0; got_fd = 0; stall_viol = 0; rdy_viol = 0; timeouts = 0;
    stop = 0;
    fork
      begin : drv
        bit acc;
        int budget;
        acc = 1'b0;
        while (bd_q.size() > 0) begin
          s_axis_tdata = bd_q[0]; s_axis_tuser = bu_q[0]; s_axis_tlast = bl_q[0];
          s_axis_tvalid = 1'b1;
          budget = 0;
          forever begin
            @(negedge aclk); acc = s_axis_tready;
            @(posedge aclk); #1;
            if (acc || budget > 50) break;
            budget++;
          end
          if (!acc) begin
            timeouts++;
            bd_q.delete(); bu_q.delete(); bl_q.delete();
          end else begin
            model_beat(bd_q[0], bu_q[0]);
            void'(bd_q.pop_front()); void'(bu_q.pop_front()); void'(bl_q.pop_front());
          end
        end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        repeat (30) @(posedge aclk);
        #1 stop = 1;
      end
      begin : rdy
        while (!stop) begin
          m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
          @(posedge aclk); #1;
        end
        m_axis_tready = 1'b1;
      end
      begin : mon
        bit pstall;
        pix_t g, e, prev;
        pstall = 1'b0;
        prev = '0;
        while (!stop) begin
          @(negedge aclk);
          g = {m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done};
          if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back(g);
            n_checks++;
            if (exp_q.size() == 0)
              $display("FAIL sb_extra pixel %0d got d=%h u=%b l=%b fd=%b expected none",
                       got_q.size()-1, g.d, g.u, g.l, g.fd);
            else begin
              e = exp_q.pop_front();
              if (g !== e)
                $display("FAIL sb_pixel %0d got d=%h u=%b l=%b fd=%b expected d=%h u=%b l=%b fd=%b",
                         got_q.size()-1, g.d, g.u, g.l, g.fd, e.d, e.u, e.l, e.fd);
              else n_pass++;
            end
          end
          if (frame_done) got_fd++;
          if (sof_err)    got_sof++;
          if (eol_err)    got_eol++;
          if (pstall && (!m_axis_tvalid || {g.d, g.u, g.l} !== {prev.d, prev.u, prev.l})) stall_viol++;
          if (m_axis_tvalid && !m_axis_tready && s_axis_tready) rdy_viol++;
          pstall = m_axis_tvalid && !m_axis_tready;
          prev = g;
        end
      end
    join
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, sof_err, eol_err, frame_done, s_axis_tready} !== '0)
      $display("FAIL reset_outputs got v=%b u=%b l=%b d=%h se=%b ee=%b fd=%b rdy=%b expected all 0",
               m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, sof_err, eol_err, frame_done, s_axis_tready);
    else n_pass++;
    do_reset();
    @(negedge aclk);
    n_checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0)
      $display("FAIL post_reset got tready=%b tvalid=%b expected 1 0", s_axis_tready, m_axis_tvalid);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    push_frame(0, -1, -1, -1);
    run_stream(1'b0);
    n_checks++; if (got_q.size() != 100) $display("FAIL basic_count got %0d expected 100", got_q.size()); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL basic_left got %0d expected 0", exp_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() < 22 || got_q[20].d !== 24'd10 || got_q[21].d !== 24'd0 || got_q[0].u !== 1'b1)
      $display("FAIL basic_pix20 got size=%0d expected p20=10 p21=0 p0.u=1", got_q.size());
    else n_pass++;
    n_checks++; if (got_fd != 1) $display("FAIL basic_fd got %0d expected 1", got_fd); else n_pass++;
    n_checks++;
    if (got_sof != 0 || got_eol != 0 || timeouts != 0)
      $display("FAIL basic_err got sof=%0d eol=%0d to=%0d expected 0 0 0", got_sof, got_eol, timeouts);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    push_frame(0, -1, -1, -1);
    run_stream(1'b1);
    n_checks++; if (got_q.size() != 100) $display("FAIL bp_count got %0d expected 100", got_q.size()); else n_pass++;
    n_checks++; if (stall_viol != 0) $display("FAIL bp_stable got %0d violations expected 0", stall_viol); else n_pass++;
    n_checks++; if (rdy_viol != 0) $display("FAIL bp_tready got %0d violations expected 0", rdy_viol); else n_pass++;
    n_checks++; if (got_fd != 1) $display("FAIL bp_fd got %0d expected 1", got_fd); else n_pass++;
  endtask

  task automatic test_pre_sof();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bd_q.push_back(48'hABCDEF_123456); bu_q.push_back(1'b0); bl_q.push_back(1'b0);
    end
    push_frame(7, -1, -1, -1);
    run_stream(1'b0);
    n_checks++; if (got_q.size() != 100) $display("FAIL presof_count got %0d expected 100", got_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[0].d !== 24'd7) $display("FAIL presof_first got size=%0d expected first pixel 7", got_q.size());
    else n_pass++;
    n_checks++; if (got_sof != 0) $display("FAIL presof_sof got %0d expected 0", got_sof); else n_pass++;
  endtask

  task automatic test_mid_sof();
    do_reset();
    push_frame(0, 20, -1, -1);
    run_stream(1'b0);
    n_checks++; if (got_sof != 1) $display("FAIL midsof_err got %0d expected 1", got_sof); else n_pass++;
    n_checks++;
    if (got_q.size() < 41 || got_q[40].u !== 1'b1 || got_q[40].d !== 24'd20)
      $display("FAIL midsof_pix40 got size=%0d expected tuser=1 d=20 on pixel 40", got_q.size());
    else n_pass++;
    n_checks++; if (got_fd != 0) $display("FAIL midsof_fd got %0d expected 0", got_fd); else n_pass++;
  endtask

  task automatic test_eol();
    do_reset();
    push_frame(0, -1, 4, 7);
    run_stream(1'b0);
    n_checks++; if (got_eol != 2) $display("FAIL eol_err got %0d expected 2", got_eol); else n_pass++;
    n_checks++;
    if (got_q.size() < 20 || got_q[9].l !== 1'b1 || got_q[19].l !== 1'b1 || got_q[15].l !== 1'b0)
      $display("FAIL eol_tlast got size=%0d expected tlast on 9,19 only", got_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_axis_tdata = (PPC*PW)'(i); s_axis_tuser = (i == 0); s_axis_tvalid = 1'b1;
      @(posedge aclk); #1;
    end
    aresetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      n_checks++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, sof_err, eol_err, frame_done, s_axis_tready} !== '0)
        $display("FAIL midreset_out cyc %0d got v=%b d=%h rdy=%b expected all 0", c, m_axis_tvalid, m_axis_tdata, s_axis_tready);
      else n_pass++;
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    m_wait = 1; m_x = 0; m_y = 0; exp_q.delete();
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    push_frame(300, -1, -1, -1);
    run_stream(1'b0);
    n_checks++; if (got_q.size() != 100) $display("FAIL midreset_count got %0d expected 100", got_q.size()); else n_pass++;
    n_checks++; if (got_fd != 1) $display("FAIL midreset_fd got %0d expected 1", got_fd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_frame(0, -1, -1, -1);
    push_frame(100, -1, -1, -1);
    run_stream(1'b0);
    n_checks++; if (got_q.size() != 200) $display("FAIL b2b_count got %0d expected 200", got_q.size()); else n_pass++;
    n_checks++; if (got_fd != 2) $display("FAIL b2b_fd got %0d expected 2", got_fd); else n_pass++;
    n_checks++;
    if (got_sof != 0 || got_eol != 0) $display("FAIL b2b_err got sof=%0d eol=%0d expected 0 0", got_sof, got_eol);
    else n_pass++;
    n_checks++;
    if (got_q.size() < 101 || got_q[100].u !== 1'b1 || got_q[100].d !== 24'd100)
      $display("FAIL b2b_sof2 got size=%0d expected pixel 100 tuser=1 d=100", got_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pre_sof();
    test_mid_sof();
    test_eol();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
